// File: rtl/display_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : display_scheduler_if
// Purpose  : Tracker-to-display bus for display_scheduler (readouts in, scan out).
// Revision : 1.0  initial release
// ============================================================================
interface display_scheduler_if;
  logic        sec_tick;
  logic        next_btn;
  logic        hold;
  logic [3:0]  mode_valid;
  logic [19:0] mode0_bcd;
  logic [19:0] mode1_bcd;
  logic [19:0] mode2_bcd;
  logic [19:0] mode3_bcd;
  logic [1:0]  mode;
  logic        mode_change;
  logic [3:0]  digit_sel_n;
  logic [4:0]  digit_bcd;

  modport master (
    output sec_tick, next_btn, hold, mode_valid,
    output mode0_bcd, mode1_bcd, mode2_bcd, mode3_bcd,
    input  mode, mode_change, digit_sel_n, digit_bcd
  );

  modport slave (
    input  sec_tick, next_btn, hold, mode_valid,
    input  mode0_bcd, mode1_bcd, mode2_bcd, mode3_bcd,
    output mode, mode_change, digit_sel_n, digit_bcd
  );
endinterface
`default_nettype wire

// File: rtl/display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : display_scheduler
// Purpose  : Rotates four tracker readouts onto a scanned 4-digit display.
//            Optional macro BLANK_LEADING_ZERO_EN blanks leading zeros.
// Revision : 1.0  initial release
// ============================================================================
module display_scheduler #(
  parameter int          ROTATE_SECS = 2,
  parameter int          SCAN_DIV    = 100000,
  parameter logic [4:0]  BLANK_CODE  = 5'h1E
) (
  input  wire logic           sys_clk,
  input  wire logic           reset,
  display_scheduler_if.slave  bus
);

  localparam logic [3:0]  c_rot_last  = 4'(ROTATE_SECS - 1);
  localparam logic [16:0] c_scan_last = 17'(SCAN_DIV - 1);

  typedef enum logic [0:0] {
    AUTO = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_count_en;

  logic [3:0]  r_sec_cnt;
  logic [1:0]  r_mode;
  logic        r_changed;
  logic        r_mode_change;

  logic [16:0] r_div;
  logic [1:0]  r_scan_idx;
  logic        r_rst_q;
  logic [19:0] r_snap;
  logic [3:0]  r_digit_sel_n;
  logic [4:0]  r_digit_bcd;

  logic        w_found;
  logic [1:0]  w_cand;
  logic [1:0]  w_next_mode;
  logic        w_sec_terminal;
  logic        w_adv_req;
  logic        w_mode_upd;
  logic        w_scan_term;
  logic [19:0] w_sel_bcd;
  logic [4:0]  w_digit_raw;
  logic [3:0]  w_blank_mask;
  logic [4:0]  w_digit;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge sys_clk) begin
    if (reset) r_state <= AUTO;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_en  = 1'b0;
    case (r_state)
      AUTO: begin
        w_count_en = bus.sec_tick;
        if (bus.hold) w_state_nxt = HOLD;
      end
      HOLD: begin
        if (!bus.hold) w_state_nxt = AUTO;
      end
      default: w_state_nxt = AUTO;
    endcase
  end

  // Advance search: first enabled readout after the current one, wrapping.
  always_comb begin
    w_found     = 1'b0;
    w_next_mode = r_mode;
    w_cand      = r_mode;
    for (int k = 1; k <= 3; k++) begin
      w_cand = r_mode + 2'(k);
      if (!w_found && bus.mode_valid[w_cand]) begin
        w_found     = 1'b1;
        w_next_mode = w_cand;
      end
    end
  end

  assign w_sec_terminal = w_count_en && (r_sec_cnt == c_rot_last);
  assign w_adv_req      = bus.next_btn || w_sec_terminal || !bus.mode_valid[r_mode];
  assign w_mode_upd     = w_adv_req && w_found;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_sec_cnt     <= 4'd0;
      r_mode        <= 2'd0;
      r_changed     <= 1'b0;
      r_mode_change <= 1'b0;
    end else begin
      if (bus.next_btn || w_sec_terminal) r_sec_cnt <= 4'd0;
      else if (w_count_en)                r_sec_cnt <= r_sec_cnt + 4'd1;
      if (w_mode_upd) r_mode <= w_next_mode;
      r_changed     <= w_mode_upd;
      r_mode_change <= r_changed;
    end
  end

  // ---------------------------------------------------------------- scan
  assign w_scan_term = (r_div == c_scan_last);

  always_comb begin
    case (r_mode)
      2'd0:    w_sel_bcd = bus.mode0_bcd;
      2'd1:    w_sel_bcd = bus.mode1_bcd;
      2'd2:    w_sel_bcd = bus.mode2_bcd;
      default: w_sel_bcd = bus.mode3_bcd;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    r_rst_q <= reset;
    if (reset) begin
      r_div      <= 17'd0;
      r_scan_idx <= 2'd0;
    end else begin
      r_div <= w_scan_term ? 17'd0 : r_div + 17'd1;
      if (w_scan_term) r_scan_idx <= r_scan_idx + 2'd1;
    end
  end

`ifdef BLANK_LEADING_ZERO_EN
  logic [1:0] r_snap_mode;
`endif

  // Snapshot refreshes only on frame wrap, reset release or mode change.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_snap <= 20'd0;
`ifdef BLANK_LEADING_ZERO_EN
      r_snap_mode <= 2'd0;
`endif
    end else if (r_rst_q || r_changed || (w_scan_term && r_scan_idx == 2'd3)) begin
      r_snap <= w_sel_bcd;
`ifdef BLANK_LEADING_ZERO_EN
      r_snap_mode <= r_mode;
`endif
    end
  end

  always_comb begin
    case (r_scan_idx)
      2'd0:    w_digit_raw = r_snap[4:0];
      2'd1:    w_digit_raw = r_snap[9:5];
      2'd2:    w_digit_raw = r_snap[14:10];
      default: w_digit_raw = r_snap[19:15];
    endcase
  end

`ifdef BLANK_LEADING_ZERO_EN
  always_comb begin
    w_blank_mask    = 4'b0000;
    w_blank_mask[3] = (r_snap[19:15] == 5'd0);
    w_blank_mask[2] = w_blank_mask[3] && (r_snap[14:10] == 5'd0);
    w_blank_mask[1] = w_blank_mask[2] && (r_snap[9:5] == 5'd0);
    if (r_snap_mode == 2'd1) w_blank_mask = 4'b0000;
  end
`else
  assign w_blank_mask = 4'b0000;
`endif

  assign w_digit = ((bus.mode_valid == 4'b0000) || w_blank_mask[r_scan_idx])
                 ? BLANK_CODE : w_digit_raw;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_digit_sel_n <= 4'b1110;
      r_digit_bcd   <= 5'd0;
    end else begin
      r_digit_sel_n <= ~(4'b0001 << r_scan_idx);
      r_digit_bcd   <= w_digit;
    end
  end

  assign bus.mode        = r_mode;
  assign bus.mode_change = r_mode_change;
  assign bus.digit_sel_n = r_digit_sel_n;
  assign bus.digit_bcd   = r_digit_bcd;

endmodule
`default_nettype wire

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Sequences the four tracker readouts (total steps, distance, seconds over 32 steps/s, high-activity time) onto one shared 4-digit seven-segment display.
- Rotates the readout on a seconds time base. Accepts a manual-advance pulse and a hold level.
- Time-multiplexes the four digits with a registered scan.
- Sits between the tracker datapath and the seven-segment decoder. All logic runs on sys_clk.

Parameters:
- ROTATE_SECS, 2, number of sec_tick pulses each readout is shown (legal range 1..15).
- SCAN_DIV, 100000, sys_clk cycles each digit is driven (minimum 2).
- BLANK_CODE, 5'h1E, digit code the decoder renders as an unlit digit.

Ports:
- sys_clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sec_tick  input  1  one-sys_clk-cycle pulse per second, already single-pulsed.
- next_btn  input  1  one-sys_clk-cycle manual-advance pulse, already single-pulsed.
- hold  input  1  level; 1 freezes auto-rotation.
- mode_valid  input  4  per-readout enable; bit n = 1 means readout n is in the rotation.
- mode0_bcd  input  20  steps readout, {bcd3,bcd2,bcd1,bcd0}, 5 bits per digit.
- mode1_bcd  input  20  distance readout, same packing.
- mode2_bcd  input  20  over-32 readout, same packing.
- mode3_bcd  input  20  high-activity readout, same packing.
- mode  output  2  index of the readout currently displayed.
- mode_change  output  1  one-cycle pulse, asserted in the cycle after mode is updated.
- digit_sel_n  output  4  active-low one-hot digit enable.
- digit_bcd  output  5  code for the currently enabled digit.

Behaviour:
- Reset values (synchronous, active-high): mode=0, mode_change=0, digit_sel_n=4'b1110, digit_bcd=0, second counter=0, scan divider=0, scan index=0, snapshot=0. Reset mid-operation returns to these values on the next sys_clk edge.
- Rotation FSM, states AUTO and HOLD:
  - AUTO goes to HOLD when hold=1. HOLD goes to AUTO when hold=0. The second counter is preserved across the transition.
  - In AUTO, each sec_tick increments the second counter.
  - On a sec_tick that arrives with the counter at ROTATE_SECS-1: advance to the next enabled readout and clear the counter.
  - In HOLD, sec_tick is ignored.
- next_btn is honoured in both states: it advances immediately and clears the second counter.
- next_btn and a rotation-terminal sec_tick in the same cycle produce exactly one advance.
- Advance rule: search mode+1, mode+2, mode+3 modulo 4, and take the first index with mode_valid set. If none of the three is set, mode is unchanged and mode_change stays 0.
- Invalidated readout: if mode_valid[mode] drops to 0, perform a forced advance on the next cycle, independent of hold. mode_change fires only when mode actually changes.
- All readouts disabled (mode_valid=0): mode is held and every digit shows BLANK_CODE.
- Scan:
  - The divider counts 0..SCAN_DIV-1. On its terminal count the scan index increments 0→1→2→3→0.
  - Index n drives digit_sel_n with bit n low. Index 0 is bcd0, the rightmost digit.
  - digit_sel_n and digit_bcd are both registered and change in the same cycle, one sys_clk after the divider terminal count.
- Snapshot (tear-free display):
  - The 20-bit value of the selected readout is latched when the scan index wraps 3→0, and at reset release.
  - digit_bcd is always taken from the snapshot, never directly from the mode inputs.
  - A mode change also reloads the snapshot on the following cycle.
- Widths: second counter is 4 bits, scan divider is 17 bits. No wrap beyond terminal counts.

Optional Feature:
- Macro name: BLANK_LEADING_ZERO_EN.
- Defined: for readouts 0, 2 and 3, the upper digits (bcd3, then bcd2, then bcd1) whose value is 0 and which lie above the highest nonzero digit are output as BLANK_CODE. bcd0 is never blanked. Readout 1 (distance) is never blanked.
- Not defined: every digit passes through unchanged.

Test Plan:
- SCAN_DIV=4, reset released, mode0_bcd={5'd1,5'd2,5'd3,5'd4}, mode_valid=4'hF -> digit_sel_n cycles 1110,1101,1011,0111 every 4 cycles, with digit_bcd 4,3,2,1 respectively.
- ROTATE_SECS=2, hold=0, 4 sec_ticks -> mode 0→1 after tick 2 and 1→2 after tick 4. mode_change pulses exactly twice.
- mode_valid=4'b1001 at mode=0, next_btn -> mode=3. Second next_btn -> mode=0.
- hold=1, 10 sec_ticks -> mode unchanged. With hold=1, next_btn -> one advance.
- mode=2, then mode_valid[2] cleared -> mode=3 within 2 cycles. mode_valid=0 -> all four digits show 5'h1E.
- With BLANK_LEADING_ZERO_EN: mode0_bcd={0,0,5'd4,5'd2} shows blank,blank,4,2, and a readout of all zeros shows blank,blank,blank,0. Without the macro, the first case shows 0,0,4,2.
